// File: rtl/projection_border_writer_pkg.sv
// Shared types and constants for the projection border writer and its scanners.
// Holds the border RAM address width, the lo/hi address map and frame phase codes.
// No logic; pure declarations and two tiny address helpers.
package projection_border_writer_pkg;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 4;

    // Frame phases driven on frame_cnt.
    localparam logic [1:0] PH_CAPTURE = 2'd0;
    localparam logic [1:0] PH_HOLD    = 2'd1;
    localparam logic [1:0] PH_RECOG   = 2'd2;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_SCAN,
        SC_WR_HI
    } scan_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN_X,
        ST_SCAN_Y,
        ST_DONE
    } top_state_e;

    // Segment k keeps its low border at 2k and its high border at 2k+1.
    function automatic logic [ADDR_W-1:0] lo_addr(input logic [CNT_W-1:0] k);
        return {{(ADDR_W-CNT_W-1){1'b0}}, k, 1'b0};
    endfunction

    function automatic logic [ADDR_W-1:0] hi_addr(input logic [CNT_W-1:0] k);
        return {{(ADDR_W-CNT_W-1){1'b0}}, k, 1'b1};
    endfunction

endpackage

// File: rtl/projection_border_writer_segment_scanner.sv
// Walks a hit vector one index per cycle and writes lo/hi border pairs of each foreground run.
// Latency: N cycles plus one extra cycle per stored segment; done pulses in the final cycle.
// No backpressure: the write port is a bare strobe, the scan pauses one cycle per hi write.
// Ports: start (1-cycle kick from IDLE), hit vector in; wr_en/wr_addr/wr_data, done, seg_cnt, ovf out.
module projection_border_writer_segment_scanner
    import projection_border_writer_pkg::*;
#(
    parameter int N       = 480,
    parameter int MAX_SEG = 1,
    parameter int MIN_SEG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N-1:0]      hit,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] wr_data,
    output logic              done,
    output logic [CNT_W-1:0]  seg_cnt,
    output logic              ovf
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    scan_state_e       st_q, st_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              in_seg_q, in_seg_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cur;
    logic              last;
    logic              close;
    logic              go_wr;
    logic [ADDR_W-1:0] close_hi;
    logic [ADDR_W-1:0] seg_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= SC_IDLE;
            idx_q    <= '0;
            in_seg_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
        end else begin
            st_q     <= st_d;
            idx_q    <= idx_d;
            in_seg_q <= in_seg_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        idx_d    = idx_q;
        in_seg_d = in_seg_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        done     = 1'b0;
        ovf      = 1'b0;
        cur      = hit[idx_q];
        last     = (idx_q == IW'(N - 1));
        close    = 1'b0;
        go_wr    = 1'b0;
        close_hi = '0;
        seg_len  = '0;

        case (st_q)
            SC_IDLE: begin
                if (start) begin
                    st_d     = SC_SCAN;
                    idx_d    = '0;
                    in_seg_d = 1'b0;
                    cnt_d    = '0;
                end
            end

            SC_SCAN: begin
                if (!in_seg_q && cur) begin
                    lo_d     = ADDR_W'(idx_q);
                    in_seg_d = 1'b1;
                end else if (in_seg_q && !cur) begin
                    close    = 1'b1;
                    close_hi = ADDR_W'(idx_q) - 1'b1;
                end else if (in_seg_q && cur && last) begin
                    // Run touches the far edge of the axis: close it at the last index.
                    close    = 1'b1;
                    close_hi = ADDR_W'(idx_q);
                end

                if (close) begin
                    in_seg_d = 1'b0;
                    hi_d     = close_hi;
                    seg_len  = close_hi - lo_q + 1'b1;
                    if (seg_len >= ADDR_W'(MIN_SEG)) begin
                        if (cnt_q < CNT_W'(MAX_SEG)) begin
                            wr_en   = 1'b1;
                            wr_addr = lo_addr(cnt_q);
                            wr_data = lo_q;
                            go_wr   = 1'b1;
                        end else begin
                            ovf = 1'b1;
                        end
                    end
                end

                if (go_wr) begin
                    st_d = SC_WR_HI;
                end else if (last) begin
                    st_d = SC_IDLE;
                    done = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            SC_WR_HI: begin
                wr_en   = 1'b1;
                wr_addr = hi_addr(cnt_q);
                wr_data = hi_q;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    st_d = SC_IDLE;
                    done = 1'b1;
                end else begin
                    st_d  = SC_SCAN;
                    idx_d = idx_q + 1'b1;
                end
            end

            default: st_d = SC_IDLE;
        endcase
    end

    assign seg_cnt = cnt_q;

endmodule

// File: rtl/projection_border_writer.sv
// Captures foreground x/y hits in frame 0, then scans both axes and writes border pairs to the RAMs.
// Latency: frame_done(0->1) to project_done_flag is at most H_PIXEL+V_PIXEL+MAX_ROW+MAX_COL+2 cycles.
// No backpressure: pixels are sampled every valid cycle, RAM writes are fire-and-forget strobes.
// Ports: pixel stream + frame_done in; row/col RAM write ports, frame_cnt, flag, counts, overflow out.
module projection_border_writer
    import projection_border_writer_pkg::*;
#(
    parameter int   H_PIXEL  = 480,
    parameter int   V_PIXEL  = 272,
    parameter int   MAX_ROW  = 1,
    parameter int   MAX_COL  = 4,
    parameter int   MIN_SEG  = 2,
    parameter logic FG_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              monoc,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              frame_done,
    output logic              row_wr_en,
    output logic [ADDR_W-1:0] row_wr_addr,
    output logic [ADDR_W-1:0] row_wr_data,
    output logic              col_wr_en,
    output logic [ADDR_W-1:0] col_wr_addr,
    output logic [ADDR_W-1:0] col_wr_data,
    output logic [1:0]        frame_cnt,
    output logic              project_done_flag,
    output logic [3:0]        num_row,
    output logic [3:0]        num_col,
    output logic              overflow
);

    localparam int XW = $clog2(H_PIXEL);
    localparam int YW = $clog2(V_PIXEL);

    top_state_e          st_q, st_d;
    logic [H_PIXEL-1:0]  xhit_q, xhit_d;
    logic [V_PIXEL-1:0]  yhit_q, yhit_d;
    logic [1:0]          frame_cnt_q, frame_cnt_d;
    logic                cap_en_q, cap_en_d;
    logic                flag_q, flag_d;
    logic [3:0]          num_row_q, num_row_d;
    logic [3:0]          num_col_q, num_col_d;
    logic                ovf_q, ovf_d;

    logic                x_start, y_start;
    logic                x_done, y_done;
    logic                x_ovf, y_ovf;
    logic [CNT_W-1:0]    x_cnt, y_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            xhit_q      <= '0;
            yhit_q      <= '0;
            frame_cnt_q <= PH_CAPTURE;
            cap_en_q    <= 1'b1;
            flag_q      <= 1'b0;
            num_row_q   <= '0;
            num_col_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            xhit_q      <= xhit_d;
            yhit_q      <= yhit_d;
            frame_cnt_q <= frame_cnt_d;
            cap_en_q    <= cap_en_d;
            flag_q      <= flag_d;
            num_row_q   <= num_row_d;
            num_col_q   <= num_col_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        xhit_d      = xhit_q;
        yhit_d      = yhit_q;
        frame_cnt_d = frame_cnt_q;
        cap_en_d    = cap_en_q;
        flag_d      = flag_q;
        num_row_d   = num_row_q;
        num_col_d   = num_col_q;
        ovf_d       = ovf_q | x_ovf | y_ovf;
        x_start     = 1'b0;

        // Hit capture only in an accepted frame 0; each axis is range-checked on its own.
        if (frame_cnt_q == PH_CAPTURE && cap_en_q && pix_valid && monoc == FG_LEVEL) begin
            if (xpos < 11'(H_PIXEL)) xhit_d[xpos[XW-1:0]] = 1'b1;
            if (ypos < 11'(V_PIXEL)) yhit_d[ypos[YW-1:0]] = 1'b1;
        end

        if (frame_done) begin
            if (frame_cnt_q == PH_RECOG) begin
                frame_cnt_d = PH_CAPTURE;
                // A scan still running owns the hit vectors and flags, so the new frame is skipped.
                if (st_q == ST_IDLE) begin
                    cap_en_d  = 1'b1;
                    xhit_d    = '0;
                    yhit_d    = '0;
                    flag_d    = 1'b0;
                    num_row_d = '0;
                    num_col_d = '0;
                    ovf_d     = 1'b0;
                end else begin
                    cap_en_d  = 1'b0;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        case (st_q)
            ST_IDLE: begin
                if (frame_done && frame_cnt_q == PH_CAPTURE && cap_en_q) begin
                    x_start = 1'b1;
                    st_d    = ST_SCAN_X;
                end
            end
            ST_SCAN_X: if (x_done) st_d = ST_SCAN_Y;
            ST_SCAN_Y: if (y_done) st_d = ST_DONE;
            ST_DONE: begin
                num_row_d = x_cnt;
                num_col_d = y_cnt;
                flag_d    = 1'b1;
                st_d      = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // The Y walk starts straight off the X scanner's final cycle.
    assign y_start = (st_q == ST_SCAN_X) && x_done;

    projection_border_writer_segment_scanner #(
        .N       (H_PIXEL),
        .MAX_SEG (MAX_ROW),
        .MIN_SEG (MIN_SEG)
    ) u_scan_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (x_start),
        .hit     (xhit_q),
        .wr_en   (row_wr_en),
        .wr_addr (row_wr_addr),
        .wr_data (row_wr_data),
        .done    (x_done),
        .seg_cnt (x_cnt),
        .ovf     (x_ovf)
    );

    projection_border_writer_segment_scanner #(
        .N       (V_PIXEL),
        .MAX_SEG (MAX_COL),
        .MIN_SEG (MIN_SEG)
    ) u_scan_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (y_start),
        .hit     (yhit_q),
        .wr_en   (col_wr_en),
        .wr_addr (col_wr_addr),
        .wr_data (col_wr_data),
        .done    (y_done),
        .seg_cnt (y_cnt),
        .ovf     (y_ovf)
    );

    assign frame_cnt         = frame_cnt_q;
    assign project_done_flag = flag_q;
    assign num_row           = num_row_q;
    assign num_col           = num_col_q;
    assign overflow          = ovf_q;

endmodule
